// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit for the single-bus datapath.
// Fetches an instruction, decodes the opcode in IR on the T2->T3 edge and
// walks the per-class T-states, raising one set of datapath strobes per cycle.
// Optional build macro CU_SINGLE_STEP_EN adds a Step input and a T0_WAIT hold
// state in front of every instruction fetch.
module control_sequencer #(
  parameter int OPW = 5,
  parameter int STW = 5
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic [31:0]    IR,
`ifdef CU_SINGLE_STEP_EN
  input  logic           Step,
`endif
  output logic           PCout,
  output logic           MARin,
  output logic           IncPC,
  output logic           Zin,
  output logic           ZLOout,
  output logic           PCin,
  output logic           Read,
  output logic           MDRin,
  output logic           MDRout,
  output logic           IRin,
  output logic           Yin,
  output logic           Cout,
  output logic           BAout,
  output logic           Gra,
  output logic           Grb,
  output logic           Rin,
  output logic           Rout,
  output logic           write,
  output logic           Run,
  output logic [STW-1:0] State
);

  // The instruction class is carried in the state itself after T3 entry, so
  // IR is only looked at while leaving T2.
  typedef enum logic [STW-1:0] {
    S_RST   = STW'(0),
    T0      = STW'(1),
    T1      = STW'(2),
    T2      = STW'(3),
    LD_T3   = STW'(4),
    LD_T4   = STW'(5),
    LD_T5   = STW'(6),
    LD_T6   = STW'(7),
    LD_T7   = STW'(8),
    LDI_T3  = STW'(9),
    LDI_T4  = STW'(10),
    LDI_T5  = STW'(11),
    ST_T3   = STW'(12),
    ST_T4   = STW'(13),
    ST_T5   = STW'(14),
    ST_T6   = STW'(15),
    ST_T7   = STW'(16),
    ALU_T3  = STW'(17),
    ALU_T4  = STW'(18),
    ALU_T5  = STW'(19),
    NOP_T3  = STW'(20),
    HLT_T3  = STW'(21),
    HALT    = STW'(22)
`ifdef CU_SINGLE_STEP_EN
    ,
    T0_WAIT = STW'(23)
`endif
  } state_t;

  localparam logic [OPW-1:0] OP_LD   = OPW'(5'b00000);
  localparam logic [OPW-1:0] OP_LDI  = OPW'(5'b00001);
  localparam logic [OPW-1:0] OP_ST   = OPW'(5'b00010);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(5'b01100);
  localparam logic [OPW-1:0] OP_ANDI = OPW'(5'b01101);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(5'b01110);
  localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

  // Where reset release and every instruction end land.
`ifdef CU_SINGLE_STEP_EN
  localparam state_t S_START = T0_WAIT;
`else
  localparam state_t S_START = T0;
`endif

  state_t         state;
  state_t         state_n;
  logic [OPW-1:0] opcode;
  logic           ir_unused;

  assign opcode    = IR[31 -: OPW];
  // Register fields and the constant are consumed by the datapath, not here.
  assign ir_unused = ^IR[31-OPW:0];
  assign State     = state;

  // State register; reset forces S_RST immediately, which zeroes all strobes.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= S_RST;
    else       state <= state_n;
  end

  // Next-state sequencing; the only opcode branch is on the T2 -> T3 edge.
  always_comb begin
    state_n = state;
    case (state)
      S_RST:  state_n = S_START;
`ifdef CU_SINGLE_STEP_EN
      T0_WAIT: state_n = Step ? T0 : T0_WAIT;
`endif
      T0:     state_n = T1;
      T1:     state_n = T2;
      T2: begin
        case (opcode)
          OP_LD:                     state_n = LD_T3;
          OP_LDI:                    state_n = LDI_T3;
          OP_ST:                     state_n = ST_T3;
          OP_ADDI, OP_ANDI, OP_ORI:  state_n = ALU_T3;
          OP_HALT:                   state_n = HLT_T3;
          default:                   state_n = NOP_T3;
        endcase
      end
      LD_T3:  state_n = LD_T4;
      LD_T4:  state_n = LD_T5;
      LD_T5:  state_n = LD_T6;
      LD_T6:  state_n = LD_T7;
      LD_T7:  state_n = S_START;
      LDI_T3: state_n = LDI_T4;
      LDI_T4: state_n = LDI_T5;
      LDI_T5: state_n = S_START;
      ST_T3:  state_n = ST_T4;
      ST_T4:  state_n = ST_T5;
      ST_T5:  state_n = ST_T6;
      ST_T6:  state_n = ST_T7;
      ST_T7:  state_n = S_START;
      ALU_T3: state_n = ALU_T4;
      ALU_T4: state_n = ALU_T5;
      ALU_T5: state_n = S_START;
      NOP_T3: state_n = S_START;
      HLT_T3: state_n = HALT;
      HALT:   state_n = HALT;
      default: state_n = S_RST;
    endcase
  end

  // Moore strobe decode from the registered state only.
  always_comb begin
    PCout  = 1'b0;
    MARin  = 1'b0;
    IncPC  = 1'b0;
    Zin    = 1'b0;
    ZLOout = 1'b0;
    PCin   = 1'b0;
    Read   = 1'b0;
    MDRin  = 1'b0;
    MDRout = 1'b0;
    IRin   = 1'b0;
    Yin    = 1'b0;
    Cout   = 1'b0;
    BAout  = 1'b0;
    Gra    = 1'b0;
    Grb    = 1'b0;
    Rin    = 1'b0;
    Rout   = 1'b0;
    write  = 1'b0;
    Run    = (state != S_RST) && (state != HALT);
    case (state)
      T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      T1: begin
        ZLOout = 1'b1;
        PCin   = 1'b1;
        Read   = 1'b1;
        MDRin  = 1'b1;
      end
      T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      // Effective address / immediate base: Rb, or 0 when Rb is R0.
      LD_T3, LDI_T3, ST_T3: begin
        Grb   = 1'b1;
        BAout = 1'b1;
        Yin   = 1'b1;
      end
      ALU_T3: begin
        Grb  = 1'b1;
        Rout = 1'b1;
        Yin  = 1'b1;
      end
      LD_T4, LDI_T4, ST_T4, ALU_T4: begin
        Cout = 1'b1;
        Zin  = 1'b1;
      end
      LD_T5, ST_T5: begin
        ZLOout = 1'b1;
        MARin  = 1'b1;
      end
      LDI_T5, ALU_T5: begin
        ZLOout = 1'b1;
        Gra    = 1'b1;
        Rin    = 1'b1;
      end
      LD_T6: begin
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      LD_T7: begin
        MDRout = 1'b1;
        Gra    = 1'b1;
        Rin    = 1'b1;
      end
      // Read stays low so MDR captures the store data from the bus.
      ST_T6: begin
        Gra   = 1'b1;
        Rout  = 1'b1;
        MDRin = 1'b1;
      end
      ST_T7: begin
        write = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized instruction stream against a table-driven
// per-opcode strobe model.
module tb_control_sequencer;

  logic        Clock;
  logic        Reset;
  logic [31:0] IR;
`ifdef CU_SINGLE_STEP_EN
  logic        Step;
`endif
  logic PCout, MARin, IncPC, Zin, ZLOout, PCin, Read, MDRin, MDRout, IRin;
  logic Yin, Cout, BAout, Gra, Grb, Rin, Rout, write, Run;
  logic [4:0] State;

  control_sequencer #(.OPW(5), .STW(5)) dut (
    .Clock(Clock), .Reset(Reset), .IR(IR),
`ifdef CU_SINGLE_STEP_EN
    .Step(Step),
`endif
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .ZLOout(ZLOout),
    .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .Yin(Yin), .Cout(Cout), .BAout(BAout), .Gra(Gra), .Grb(Grb), .Rin(Rin),
    .Rout(Rout), .write(write), .Run(Run), .State(State)
  );

  localparam logic [17:0] M_PCOUT  = 18'd1 << 17;
  localparam logic [17:0] M_MARIN  = 18'd1 << 16;
  localparam logic [17:0] M_INCPC  = 18'd1 << 15;
  localparam logic [17:0] M_ZIN    = 18'd1 << 14;
  localparam logic [17:0] M_ZLOOUT = 18'd1 << 13;
  localparam logic [17:0] M_PCIN   = 18'd1 << 12;
  localparam logic [17:0] M_READ   = 18'd1 << 11;
  localparam logic [17:0] M_MDRIN  = 18'd1 << 10;
  localparam logic [17:0] M_MDROUT = 18'd1 << 9;
  localparam logic [17:0] M_IRIN   = 18'd1 << 8;
  localparam logic [17:0] M_YIN    = 18'd1 << 7;
  localparam logic [17:0] M_COUT   = 18'd1 << 6;
  localparam logic [17:0] M_BAOUT  = 18'd1 << 5;
  localparam logic [17:0] M_GRA    = 18'd1 << 4;
  localparam logic [17:0] M_GRB    = 18'd1 << 3;
  localparam logic [17:0] M_RIN    = 18'd1 << 2;
  localparam logic [17:0] M_ROUT   = 18'd1 << 1;
  localparam logic [17:0] M_WRITE  = 18'd1;
  localparam logic [17:0] M_BUS    = M_PCOUT | M_ZLOOUT | M_MDROUT | M_ROUT | M_BAOUT | M_COUT;

`ifdef CU_SINGLE_STEP_EN
  localparam int WAITS = 1;
`else
  localparam int WAITS = 0;
`endif

  logic [17:0] obs;
  assign obs = {PCout, MARin, IncPC, Zin, ZLOout, PCin, Read, MDRin, MDRout, IRin,
                Yin, Cout, BAout, Gra, Grb, Rin, Rout, write};

  int n_tests = 0;
  int n_fail  = 0;
  logic [17:0] exp_q[$];

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One cycle's worth of checks: strobes, Run and bus-driver exclusivity.
  task automatic check_cycle(input string tag, input logic [17:0] m, input logic run_exp);
    chk_eq({tag, "_strobes"}, 32'(obs), 32'(m));
    chk_eq({tag, "_run"}, 32'(Run), 32'(run_exp));
    chk_eq({tag, "_bus_onehot"}, 32'($countones(obs & M_BUS) <= 1), 32'd1);
  endtask

  // Reference model: the cycle-by-cycle strobe sets each opcode calls for.
  task automatic build_seq(input logic [4:0] op);
    exp_q.delete();
    if (WAITS == 1) exp_q.push_back(18'd0);
    exp_q.push_back(M_PCOUT | M_MARIN | M_INCPC | M_ZIN);
    exp_q.push_back(M_ZLOOUT | M_PCIN | M_READ | M_MDRIN);
    exp_q.push_back(M_MDROUT | M_IRIN);
    case (op)
      5'b00000: begin
        exp_q.push_back(M_GRB | M_BAOUT | M_YIN);
        exp_q.push_back(M_COUT | M_ZIN);
        exp_q.push_back(M_ZLOOUT | M_MARIN);
        exp_q.push_back(M_READ | M_MDRIN);
        exp_q.push_back(M_MDROUT | M_GRA | M_RIN);
      end
      5'b00001: begin
        exp_q.push_back(M_GRB | M_BAOUT | M_YIN);
        exp_q.push_back(M_COUT | M_ZIN);
        exp_q.push_back(M_ZLOOUT | M_GRA | M_RIN);
      end
      5'b00010: begin
        exp_q.push_back(M_GRB | M_BAOUT | M_YIN);
        exp_q.push_back(M_COUT | M_ZIN);
        exp_q.push_back(M_ZLOOUT | M_MARIN);
        exp_q.push_back(M_GRA | M_ROUT | M_MDRIN);
        exp_q.push_back(M_WRITE);
      end
      5'b01100, 5'b01101, 5'b01110: begin
        exp_q.push_back(M_GRB | M_ROUT | M_YIN);
        exp_q.push_back(M_COUT | M_ZIN);
        exp_q.push_back(M_ZLOOUT | M_GRA | M_RIN);
      end
      default: exp_q.push_back(18'd0);
    endcase
  endtask

  // Runs one instruction starting from the negedge before its first cycle.
  // abort_at >= 0 pulses Reset after checking that cycle index.
  task automatic run_instr(input string tag, input logic [31:0] ir, input int abort_at);
    int n;
    build_seq(ir[31:27]);
    n = exp_q.size();
    IR = ir;
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      check_cycle($sformatf("%s_c%0d", tag, i), exp_q[i], 1'b1);
      if (i == abort_at) begin
        Reset = 1'b1;
        #1;
        chk_eq({tag, "_abort_strobes"}, 32'(obs), 32'd0);
        chk_eq({tag, "_abort_run"}, 32'(Run), 32'd0);
        chk_eq({tag, "_abort_state"}, 32'(State), 32'd0);
        @(negedge Clock);
        Reset = 1'b0;
        break;
      end
      // Decode already happened; later IR changes must not disturb sequencing.
      if (i >= 3 + WAITS) IR = $urandom;
    end
  endtask

  initial begin
    logic [4:0]  op;
    logic [31:0] ir;
    Reset = 1'b1;
    IR    = 32'h0;
`ifdef CU_SINGLE_STEP_EN
    Step  = 1'b1;
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      chk_eq("rst_strobes", 32'(obs), 32'd0);
      chk_eq("rst_run", 32'(Run), 32'd0);
      chk_eq("rst_state", 32'(State), 32'd0);
    end
    Reset = 1'b0;

    run_instr("ldi", 32'h08800075, -1);
    run_instr("ld", 32'h00080045, -1);
    run_instr("st", 32'h1190001F, -1);
    run_instr("addi", 32'h622FFFFD, -1);

    for (int k = 0; k < 40; k++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'b11011) op = 5'b11010;
      ir = {op, 27'($urandom)};
      run_instr("rand", ir, -1);
    end

    // Reset in ld T6, then a clean restart from fetch.
    run_instr("ld_abort", 32'h00080045, 6 + WAITS);
    run_instr("after_abort", 32'h08800075, -1);

    run_instr("halt", 32'hD8000000, -1);
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      check_cycle("halted", 18'd0, 1'b0);
    end
    Reset = 1'b1;
    #1;
    chk_eq("halt_rst_state", 32'(State), 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    run_instr("post_halt", 32'h622FFFFD, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
